// File: rtl/mux_2x1_stream_pkg.sv
// Shared constants for the 2-to-1 stream multiplexer slice.
// Select encoding, default widths and the output-register state encoding.
package mux_2x1_stream_pkg;

    // Source index carried on out_sel and used by the arbiter.
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    // Default data and counter widths.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // Output register state: EMPTY holds nothing, FULL holds one word.
    typedef logic [0:0] state_t;
    localparam state_t ST_EMPTY = 1'b0;
    localparam state_t ST_FULL  = 1'b1;

    // Index of the source that is not `sel`.
    function automatic logic other_sel(input logic sel);
        return (sel == SEL_IN1) ? SEL_IN2 : SEL_IN1;
    endfunction

endpackage

// File: rtl/mux_2x1_stream_if.sv
// Signal bundle for mux_2x1_stream: two input lanes, the merged output and
// the per-lane transfer counters.
//
// Handshake rule for every lane: a word moves on a rising edge where its
// valid and ready are both high. A producer holds data stable while valid is
// high and ready is low. Ready may depend combinationally on valid.
//
// modport master: the environment side (drives input lanes and out_ready).
// modport slave : the multiplexer side (drives readies, output and counters).
interface mux_2x1_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in1;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in2;
    logic             in2_valid;
    logic             in2_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             out_sel;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    modport master (
        output in1, in1_valid, in2, in2_valid, out_ready,
        input  in1_ready, in2_ready, out, out_valid, out_sel, cnt1, cnt2
    );

    modport slave (
        input  in1, in1_valid, in2, in2_valid, out_ready,
        output in1_ready, in2_ready, out, out_valid, out_sel, cnt1, cnt2
    );

endinterface

// File: rtl/mux_2x1_stream_rr_arb_2.sv
// Two-way arbiter for mux_2x1_stream.
// Default build: round-robin; on a tie the requester that did not win last
// is granted. last_sel resets to SEL_IN2 so in1 wins the first tie, and it
// moves only when `advance` reports an accepted transfer.
// With MUX_2X1_STREAM_FIXED_PRIO_EN defined: strict priority to req[0]
// and no pointer state at all.
module rr_arb_2
    import mux_2x1_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

`ifdef MUX_2X1_STREAM_FIXED_PRIO_EN

    // Clock, reset and advance have no role without a pointer.
    wire unused_ok = &{1'b0, clk, rst, advance};

    // Strict priority: req[0] always wins when present.
    always_comb begin
        gnt     = 2'b00;
        gnt_idx = SEL_IN1;
        if (req[0]) begin
            gnt     = 2'b01;
            gnt_idx = SEL_IN1;
        end else if (req[1]) begin
            gnt     = 2'b10;
            gnt_idx = SEL_IN2;
        end
    end

`else

    logic last_sel;

    // Pointer to the most recent winner; updated only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sel <= SEL_IN2;
        end else if (advance) begin
            last_sel <= gnt_idx;
        end
    end

    // Grant the lone requester, or on a tie the one that did not win last.
    always_comb begin
        gnt     = 2'b00;
        gnt_idx = SEL_IN1;
        case (req)
            2'b01: begin
                gnt     = 2'b01;
                gnt_idx = SEL_IN1;
            end
            2'b10: begin
                gnt     = 2'b10;
                gnt_idx = SEL_IN2;
            end
            2'b11: begin
                gnt_idx = other_sel(last_sel);
                gnt     = (gnt_idx == SEL_IN2) ? 2'b10 : 2'b01;
            end
            default: begin
                gnt     = 2'b00;
                gnt_idx = SEL_IN1;
            end
        endcase
    end

`endif

endmodule

// File: rtl/mux_2x1_stream.sv
// mux_2x1_stream: merges two valid/ready lanes onto one registered output.
// out_sel tags each output word with its source (0 = in1, 1 = in2) so a
// downstream 1x2 demux can re-split the stream. cnt1/cnt2 count accepted
// words per lane and saturate at all ones.
// Build option: define MUX_2X1_STREAM_FIXED_PRIO_EN for strict in1 priority
// instead of round-robin (handled inside rr_arb_2).
// dbg_state exposes the output-register state (ST_EMPTY / ST_FULL).
module mux_2x1_stream
    import mux_2x1_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    mux_2x1_stream_if.slave          bus,
    output state_t                   dbg_state
);

    state_t           state;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
    logic [CNT_W-1:0] cnt1_q;
    logic [CNT_W-1:0] cnt2_q;

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             gnt_idx;
    logic             can_load;
    logic             load;
    logic             acc1;
    logic             acc2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign req = {bus.in2_valid, bus.in1_valid};

    rr_arb_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The register can take a word when empty or being drained this cycle.
    // Readies are held low during reset so nothing is consumed while the
    // block is being cleared.
    always_comb begin
        can_load      = (state == ST_EMPTY) || bus.out_ready;
        load          = can_load && (|req) && !rst;
        bus.in1_ready = gnt[0] && can_load && !rst;
        bus.in2_ready = gnt[1] && can_load && !rst;
        acc1          = bus.in1_valid && bus.in1_ready;
        acc2          = bus.in2_valid && bus.in2_ready;
    end

    // Output register FSM: refill on load (no bubble), empty when drained
    // with nothing to take, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            out_q <= '0;
            sel_q <= SEL_IN1;
        end else if (load) begin
            state <= ST_FULL;
            out_q <= (gnt_idx == SEL_IN2) ? bus.in2 : bus.in1;
            sel_q <= gnt_idx;
        end else if (bus.out_ready) begin
            state <= ST_EMPTY;
        end
    end

    // Per-lane saturating transfer counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            if (acc1 && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CNT_ONE;
            end
            if (acc2 && (cnt2_q != '1)) begin
                cnt2_q <= cnt2_q + CNT_ONE;
            end
        end
    end

    // Registered outputs only; no path from input data to out.
    always_comb begin
        bus.out       = out_q;
        bus.out_valid = (state == ST_FULL);
        bus.out_sel   = sel_q;
        bus.cnt1      = cnt1_q;
        bus.cnt2      = cnt2_q;
        dbg_state     = state;
    end

endmodule
